// File: rtl/dmem_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_ctrl: parametrised data-memory controller between the MEM stage and a
// word-organised storage array. Byte/half/word loads and stores with sign or
// zero extension, misalignment detection and a valid/ready handshake with a
// configurable response latency.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two, 16..65536)
//   LATENCY    cycles from accept to response (1..4)
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   controller can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed  load extension: 1 = sign, 0 = zero (byte/half loads only)
//   req_addr    byte address, wraps modulo DEPTH*4
//   req_wdata   store data, sub-word taken from the low bits
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   extended load data; 0 for stores and errors
//   rsp_err     misaligned or reserved-size request
// ----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Storage array; contents are deliberately not reset.
    logic [31:0]      r_mem [DEPTH];

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;
    logic [31:0]      r_hold_rdata;
    logic             r_hold_err;

    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic             w_accept;
    logic             w_err;
    logic             w_store;
    logic [3:0]       w_be;
    logic [31:0]      w_wr_lanes;
    logic [31:0]      w_rd_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic [31:0]      w_rsp_data;
    logic             w_addr_unused;

    assign w_idx         = req_addr[IDX_W+1:2];
    assign w_lane        = req_addr[1:0];
    // Address bits above the array size are intentionally ignored (wrap).
    assign w_addr_unused = ^req_addr[31:IDX_W+2];

    assign w_accept  = req_valid & r_req_ready;
    assign w_store   = w_accept & req_we & ~w_err;
    assign w_rd_word = r_mem[w_idx];

    // Alignment / reserved-size check.
    always_comb begin
        w_err = 1'b0;
        case (req_size)
            SZ_B:    w_err = 1'b0;
            SZ_H:    w_err = w_lane[0];
            SZ_W:    w_err = |w_lane;
            default: w_err = 1'b1;
        endcase
    end

    // Lane enables and replicated store data so each lane sees its sub-word.
    always_comb begin
        w_be       = 4'b0000;
        w_wr_lanes = req_wdata;
        case (req_size)
            SZ_B: begin
                w_be       = 4'b0001 << w_lane;
                w_wr_lanes = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_lanes = {2{req_wdata[15:0]}};
            end
            SZ_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Byte-enabled store commit at the accept edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_store && w_be[i]) begin
                r_mem[w_idx][8*i +: 8] <= w_wr_lanes[8*i +: 8];
            end
        end
    end

    // Sub-word select and extension of the word read at the accept edge.
    always_comb begin
        w_byte      = 8'(w_rd_word >> {w_lane, 3'b000});
        w_half      = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        w_load_data = w_rd_word;
        case (req_size)
            SZ_B: w_load_data = req_signed ? {{24{w_byte[7]}}, w_byte}
                                           : {24'h000000, w_byte};
            SZ_H: w_load_data = req_signed ? {{16{w_half[15]}}, w_half}
                                           : {16'h0000, w_half};
            default: w_load_data = w_rd_word;
        endcase
    end

    assign w_rsp_data = (req_we || w_err) ? 32'h0000_0000 : w_load_data;

    // Handshake/latency FSM; response data is captured at accept and held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'h0000_0000;
            r_rsp_err    <= 1'b0;
            r_hold_rdata <= 32'h0000_0000;
            r_hold_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (LATENCY == 1) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_data;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state      <= ST_WAIT;
                            r_cnt        <= CNT_W'(LATENCY - 1);
                            r_req_ready  <= 1'b0;
                            r_hold_rdata <= w_rsp_data;
                            r_hold_err   <= w_err;
                        end
                    end
                end
                ST_WAIT: begin
                    // Last wait cycle: release ready together with the response.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_hold_rdata;
                        r_rsp_err   <= r_hold_err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_ctrl: drives two controller instances (LATENCY=1/DEPTH=256 and
// LATENCY=3/DEPTH=16) with directed requests and checks every cycle against a
// byte-array model with a response queue, plus literal expected load values.
// ----------------------------------------------------------------------------
module tb_dmem_ctrl;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        bit          has_lit;
        logic [31:0] lit;
        logic        lit_err;
    } pend_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2] = '{1'b1, 1'b1};
    logic        req_valid  [2] = '{1'b0, 1'b0};
    logic        req_we     [2] = '{1'b0, 1'b0};
    logic [1:0]  req_size   [2] = '{2'b00, 2'b00};
    logic        req_signed [2] = '{1'b0, 1'b0};
    logic [31:0] req_addr   [2] = '{32'h0, 32'h0};
    logic [31:0] req_wdata  [2] = '{32'h0, 32'h0};
    logic        req_ready  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    // Literal expectation attached to the request being driven.
    bit          lit_en [2] = '{1'b0, 1'b0};
    logic [31:0] lit_rd [2] = '{32'h0, 32'h0};
    bit          lit_er [2] = '{1'b0, 1'b0};

    // Model view of what the outputs must be in the current cycle.
    bit          m_valid   [2] = '{1'b0, 1'b0};
    bit          m_ready   [2] = '{1'b1, 1'b1};
    logic [31:0] m_rdata   [2] = '{32'h0, 32'h0};
    bit          m_err     [2] = '{1'b0, 1'b0};
    bit          m_has_lit [2] = '{1'b0, 1'b0};
    logic [31:0] m_lit     [2] = '{32'h0, 32'h0};
    bit          m_lit_err [2] = '{1'b0, 1'b0};

    int n_cmp  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        localparam int unsigned DEP = (g == 0) ? 256 : 16;

        dmem_ctrl #(.DEPTH(DEP), .LATENCY(LAT)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_size   (req_size[g]),
            .req_signed (req_signed[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );

        logic [7:0] mm [DEP*4];
        pend_t      pq [$];
        int         cyc  = 0;
        int         busy = 0;

        // Behavioural model: byte array, pending-response queue, busy window.
        always @(posedge clk or negedge rst_n[g]) begin
            pend_t       e;
            int unsigned a;
            int          nb;
            logic [31:0] v;
            bit          er;
            if (!rst_n[g]) begin
                pq.delete();
                busy         = 0;
                m_valid[g]   = 1'b0;
                m_ready[g]   = 1'b1;
                m_rdata[g]   = 32'h0;
                m_err[g]     = 1'b0;
                m_has_lit[g] = 1'b0;
            end else begin
                if (cyc >= busy && req_valid[g]) begin
                    a  = req_addr[g] % (DEP * 4);
                    nb = (req_size[g] == 2'd0) ? 1 : (req_size[g] == 2'd1) ? 2 : 4;
                    er = (req_size[g] == 2'd3) ||
                         (req_size[g] == 2'd1 && (a % 2) != 0) ||
                         (req_size[g] == 2'd2 && (a % 4) != 0);
                    e.due = cyc + int'(LAT);
                    busy  = cyc + int'(LAT);
                    e.err = er;
                    e.rdata = 32'h0;
                    if (!er && req_we[g]) begin
                        for (int i = 0; i < nb; i++) mm[a + i] = 8'(req_wdata[g] >> (8 * i));
                    end else if (!er) begin
                        v = 32'h0;
                        for (int i = 0; i < nb; i++) v = v | (32'(mm[a + i]) << (8 * i));
                        if (req_signed[g] && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                        e.rdata = v;
                    end
                    e.has_lit = lit_en[g];
                    e.lit     = lit_rd[g];
                    e.lit_err = lit_er[g];
                    pq.push_back(e);
                end
                cyc = cyc + 1;
                m_valid[g]   = 1'b0;
                m_has_lit[g] = 1'b0;
                if (pq.size() > 0 && pq[0].due == cyc) begin
                    e = pq.pop_front();
                    m_valid[g]   = 1'b1;
                    m_rdata[g]   = e.rdata;
                    m_err[g]     = e.err;
                    m_has_lit[g] = e.has_lit;
                    m_lit[g]     = e.lit;
                    m_lit_err[g] = e.lit_err;
                end
                m_ready[g] = (cyc >= busy);
            end
        end
    end

    task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got 0x%08h expected 0x%08h at %0t", g, nm, act, exp, $time);
        end
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            chk(g, "rsp_valid", 32'(rsp_valid[g]), 32'(m_valid[g]));
            chk(g, "req_ready", 32'(req_ready[g]), 32'(m_ready[g]));
            chk(g, "rsp_rdata", rsp_rdata[g], m_rdata[g]);
            chk(g, "rsp_err",   32'(rsp_err[g]), 32'(m_err[g]));
            if (m_valid[g] && m_has_lit[g]) begin
                chk(g, "lit_rdata", rsp_rdata[g], m_lit[g]);
                chk(g, "lit_err",   32'(rsp_err[g]), 32'(m_lit_err[g]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Present one request and hold it until the controller takes it.
    task automatic send(input int g, input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] lrd, input bit ler);
        bit acc;
        int tries;
        req_valid[g]  = 1'b1;
        req_we[g]     = we;
        req_size[g]   = sz;
        req_signed[g] = sg;
        req_addr[g]   = addr;
        req_wdata[g]  = wd;
        lit_en[g]     = 1'b1;
        lit_rd[g]     = lrd;
        lit_er[g]     = ler;
        tries = 0;
        do begin
            acc = m_ready[g];
            @(posedge clk);
            #2;
            tries++;
        end while (!acc && tries < 16);
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL inst%0d accept_timeout: got no accept expected accept within 16 cycles", g);
        end
        req_valid[g] = 1'b0;
        lit_en[g]    = 1'b0;
    endtask

    initial begin
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        idle(2);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle(1);

        // LATENCY=1, DEPTH=256
        send(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        send(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        send(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
        send(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h000000DE, 0);
        send(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
        send(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'h0000DEAD, 0);
        send(0, 1, 2'b00, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0);
        send(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0);
        send(0, 1, 2'b01, 0, 32'h11, 32'h12345678, 32'h0, 1);
        send(0, 1, 2'b10, 0, 32'h12, 32'h12345678, 32'h0, 1);
        send(0, 1, 2'b11, 0, 32'h00, 32'h12345678, 32'h0, 1);
        send(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0);
        send(0, 1, 2'b10, 0, 32'h14, 32'h11223344, 32'h0, 0);
        send(0, 1, 2'b01, 0, 32'h16, 32'h0000CAFE, 32'h0, 0);
        send(0, 0, 2'b10, 0, 32'h14, 32'h0, 32'hCAFE3344, 0);
        send(0, 0, 2'b01, 1, 32'h16, 32'h0, 32'hFFFFCAFE, 0);
        send(0, 0, 2'b00, 1, 32'h14, 32'h0, 32'h00000044, 0);
        send(0, 1, 2'b10, 0, 32'h410, 32'h0BADF00D, 32'h0, 0);
        send(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0BADF00D, 0);
        idle(3);

        // LATENCY=3, DEPTH=16: back-to-back, wrap-around, errors
        send(1, 1, 2'b10, 0, 32'h40, 32'hA5A50F0F, 32'h0, 0);
        send(1, 0, 2'b10, 0, 32'h00, 32'h0, 32'hA5A50F0F, 0);
        send(1, 0, 2'b00, 1, 32'h01, 32'h0, 32'h0000000F, 0);
        send(1, 0, 2'b01, 1, 32'h02, 32'h0, 32'hFFFFA5A5, 0);
        send(1, 0, 2'b11, 0, 32'h08, 32'h0, 32'h0, 1);
        send(1, 0, 2'b01, 0, 32'h03, 32'h0, 32'h0, 1);
        idle(4);

        // Reset one cycle after a load is accepted: response dropped
        send(1, 1, 2'b10, 0, 32'h20, 32'h13579BDF, 32'h0, 0);
        send(1, 0, 2'b10, 0, 32'h00, 32'h0, 32'hA5A50F0F, 0);
        rst_n[1] = 1'b0;
        idle(2);
        rst_n[1] = 1'b1;
        idle(1);
        chk(1, "post_rst_ready", 32'(req_ready[1]), 32'h1);

        // Reset one cycle after a store is accepted: store stays committed
        send(1, 1, 2'b10, 0, 32'h24, 32'h2468ACE0, 32'h0, 0);
        rst_n[1] = 1'b0;
        idle(2);
        rst_n[1] = 1'b1;
        idle(1);
        send(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h13579BDF, 0);
        send(1, 0, 2'b10, 0, 32'h24, 32'h0, 32'h2468ACE0, 0);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
